regfile_multiport_clr: RTL
==========================

Name: regfile_multiport_clr

Overview:
- Parametrised successor to the 64x32 CPU register file: configurable width, depth and hardwired-zero index.
- Two combinational read ports and one synchronous write port.
- A clear sequencer zeroes every entry one per cycle after reset or on request, with a Busy indication.
- Sits in the decode/writeback stage of the processor datapath; writes occur on the rising edge.

Parameters:
WIDTH, 64, data width of each register and of BusA/BusB/BusW
DEPTH, 32, number of registers (2..256, need not be a power of 2)
ZERO_REG, 31, index that always reads 0 and ignores writes; ZERO_REG >= DEPTH disables the feature
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
ClearReq  input  1  request to re-zero entire file (sampled in IDLE only)
RA  input  ADDR_W  read address, port A
RB  input  ADDR_W  read address, port B
RW  input  ADDR_W  write address
BusW  input  WIDTH  write data
RegWr  input  1  write enable
BusA  output  WIDTH  read data, port A (combinational)
BusB  output  WIDTH  read data, port B (combinational)
Busy  output  1  high while clear sequence is running
WrDrop  output  1  registered one-cycle pulse: a requested write was discarded

Behaviour:
- FSM states: CLEAR, IDLE. State, clear pointer, Busy and WrDrop are asynchronously reset. Register array contents are not reset directly; they are zeroed by the sequencer.
- Reset asserted: state=CLEAR, ptr=0, Busy=1, WrDrop=0 immediately, held while Reset=1.
- CLEAR, each rising edge with Reset=0: registers[ptr]<=0 and ptr<=ptr+1.
  - On the edge that writes ptr==DEPTH-1: state<=IDLE, Busy<=0, ptr<=0.
  - Busy is therefore high for exactly DEPTH edges after Reset deasserts.
- IDLE with ClearReq=1: state<=CLEAR, Busy<=1, ptr<=0 on the next edge. ClearReq has priority over a same-cycle write; that write is dropped (WrDrop=1 next cycle). ClearReq is ignored while in CLEAR (no restart).
- Write, IDLE: if RegWr=1, RW!=ZERO_REG and RW<DEPTH, then registers[RW]<=BusW on the rising edge.
  - Writes to ZERO_REG or to an out-of-range RW are silently ignored; WrDrop stays 0.
- Write, CLEAR: RegWr=1 is discarded, and WrDrop<=1 for the following cycle. WrDrop is 0 in every other cycle.
- Reads: BusA/BusB = 0 when the address equals ZERO_REG, the address >= DEPTH, or state==CLEAR (Busy=1). Otherwise they equal the stored value.
- Read-during-write, same address, without bypass: BusA/BusB show the old value until the edge, then the new value.
- RA==RB: both ports return identical data.
- Reset mid-clear: the sequence restarts from ptr=0 and takes the full DEPTH cycles.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: in IDLE, when RegWr=1, RW!=ZERO_REG, RW<DEPTH and RA==RW, BusA=BusW combinationally in the same cycle. The same rule applies to RB/BusB. No bypass in CLEAR.
- Undefined: no forwarding; the behaviour is as described above.

Test Plan:
- Reset pulse, WIDTH=64, DEPTH=32 -> Busy=1 for exactly 32 rising edges after release; then Busy=0 and all 32 reads (RA sweep) return 0.
- IDLE: write RW=1 BusW=0x1234, then RW=2 BusW=0xFFFF_FFFF_FFFF_FFFF; RA=1, RB=2 -> BusA=0x1234, BusB=all-ones. Write RW=31 BusW=5 -> read RA=31 gives 0, WrDrop stays 0.
- Same-cycle write RW=3 BusW=0xAB with RA=3 -> without REGFILE_BYPASS_EN, BusA=old 0 before the edge and 0xAB after; with it defined, BusA=0xAB in the same cycle.
- Fill r0..r30 with nonzero data, pulse ClearReq together with RegWr RW=4 -> WrDrop=1 for one cycle, Busy=1 for 32 cycles, BusA=0 throughout. Afterwards all registers read 0, including r4.
- During CLEAR, assert RegWr RW=7 BusW=0x77 at cycle 5 -> WrDrop pulses 1 cycle; after Busy falls, RA=7 reads 0.
- DEPTH=20, ZERO_REG=0: write RW=25 BusW=9 -> ignored, read RA=25 gives 0; reset asserted at clear cycle 10 -> Busy stays high 20 cycles after release.

Source files
------------

// File: rtl/regfile_multiport_clr.sv
// regfile_multiport_clr: parametrised register file with two combinational
// read ports, one synchronous write port and a clear sequencer that zeroes
// one entry per cycle after reset or on ClearReq.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data (BusW) to a read port whose address matches RW while IDLE.
module regfile_multiport_clr #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 31,
  parameter int ADDR_W   = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ClearReq,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic [WIDTH-1:0]  BusW,
  input  logic              RegWr,
  output logic [WIDTH-1:0]  BusA,
  output logic [WIDTH-1:0]  BusB,
  output logic              Busy,
  output logic              WrDrop
);

  // Index width actually needed to address DEPTH entries; addresses are
  // range-checked before they are truncated to this width.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } stateT;

  stateT             stateReg;
  logic [ADDR_W-1:0] clrPtrReg;
  logic [WIDTH-1:0]  regs [DEPTH];

  logic wrValid;
  logic wrAccept;

  // An address is usable when it lies inside the file and is not the
  // hardwired-zero entry (ZERO_REG >= DEPTH makes the second test vacuous).
  function automatic logic addrValid(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < 32'(DEPTH)) && (32'(addr) != 32'(ZERO_REG));
  endfunction

  assign wrValid  = RegWr && addrValid(RW);
  // A clear request wins over a write presented in the same IDLE cycle.
  assign wrAccept = (stateReg == IDLE) && wrValid && !ClearReq;

  // Clear sequencer: walks the pointer through every entry, then idles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateReg  <= CLEAR;
      clrPtrReg <= '0;
      Busy      <= 1'b1;
      WrDrop    <= 1'b0;
    end else begin
      case (stateReg)
        CLEAR: begin
          WrDrop <= RegWr;
          if (clrPtrReg == ADDR_W'(DEPTH - 1)) begin
            stateReg  <= IDLE;
            Busy      <= 1'b0;
            clrPtrReg <= '0;
          end else begin
            clrPtrReg <= clrPtrReg + ADDR_W'(1);
          end
        end
        default: begin
          WrDrop <= ClearReq && RegWr;
          if (ClearReq) begin
            stateReg  <= CLEAR;
            Busy      <= 1'b1;
            clrPtrReg <= '0;
          end
        end
      endcase
    end
  end

  // Storage update: zero the pointed entry while clearing, else accept writes.
  // While Reset is held the pointer sits at 0 and reads are forced to zero,
  // so zeroing entry 0 repeatedly is harmless.
  always_ff @(posedge Clk) begin
    if (stateReg == CLEAR) begin
      regs[clrPtrReg[IDX_W-1:0]] <= '0;
    end else if (wrAccept) begin
      regs[RW[IDX_W-1:0]] <= BusW;
    end
  end

  // Two identical read ports: gi=0 drives BusA from RA, gi=1 drives BusB from RB.
  for (genvar gi = 0; gi < 2; gi++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;

    assign addr = (gi == 0) ? RA : RB;

    // Combinational read, forced to zero while clearing or for unusable addresses.
    always_comb begin
      data = '0;
      if ((stateReg == IDLE) && addrValid(addr)) begin
`ifdef REGFILE_BYPASS_EN
        if (wrValid && (addr == RW)) begin
          data = BusW;
        end else begin
          data = regs[addr[IDX_W-1:0]];
        end
`else
        data = regs[addr[IDX_W-1:0]];
`endif
      end
    end

    if (gi == 0) begin : gPortA
      assign BusA = data;
    end else begin : gPortB
      assign BusB = data;
    end
  end

endmodule
